div_sequencer: RTL and testbench

Multi-cycle signed 32-bit divide controller for the CPU datapath. It accepts a divide request from the control unit and produces quotient and remainder by iterative restoring division, one bit per clock. Results use the same signed semantics as the existing combinational divider, so HI/LO writeback is unchanged. It sits between the control unit, which issues `start` and waits on `busy`/`done`, and the HI/LO register inputs, which it drives with the 64-bit `{remainder, quotient}` word.

---
 rtl/div_pkg.sv | 31 +++
 rtl/div_step.sv | 36 +++
 rtl/div_sequencer.sv | 175 +++++++++++++++++
 tb/tb_div_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared state encoding and constants for the sequential
//               signed divider (div_sequencer / div_step).
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand width of the divider datapath
    localparam int DEF_WIDTH = 32;

    // Number of restoring iterations for a full-width quotient
    localparam int ITER_COUNT = 32;

    // Quotient reported for a divide by zero
    localparam logic [31:0] Q_DIV0 = 32'hFFFF_FFFF;

    // Most negative operand; INT_MIN / -1 wraps back to INT_MIN
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step. Shifts {P, Q}
//               left by one, subtracts the divisor magnitude from P when it
//               fits and records the outcome in the new quotient LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH-1:0] p_out,
    output logic [WIDTH-1:0] q_out
);

    // Partial remainder after the shift; one extra bit so the compare against
    // a divisor magnitude of 2^(WIDTH-1) never overflows
    logic [WIDTH:0] shifted;
    logic           fits;

    // Shift, trial-compare and conditionally subtract. The remainder after a
    // successful subtract is below the divisor, so it always fits in WIDTH bits.
    always_comb begin
        shifted = {p_in, q_in[WIDTH-1]};
        fits    = (shifted >= divisor);
        p_out   = fits ? WIDTH'(shifted - divisor) : shifted[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], fits};
    end

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle signed divide controller. Restoring division on
//               operand magnitudes, one quotient bit per clock, followed by a
//               sign fix-up cycle. Quotient truncates toward zero, remainder
//               takes the sign of the dividend. z = {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] z
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;

    // Iteration counter and restoring-division working registers
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] p;          // partial remainder magnitude
    logic [WIDTH-1:0] q;          // dividend magnitude shifting into quotient
    logic [WIDTH:0]   dmag;       // divisor magnitude, wide enough for |INT_MIN|
    logic             sign_q;
    logic             sign_r;
    logic             zero;

    // Combinational helpers
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   b_mag;
    logic [WIDTH-1:0] p_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes. |INT_MIN| is 2^(WIDTH-1), which is still correct as
    // an unsigned WIDTH-bit dividend; the divisor is kept one bit wider.
    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_ext = {b[WIDTH-1], b};
        b_mag = b_ext[WIDTH] ? -b_ext : b_ext;
    end

    div_step #(
        .WIDTH   (WIDTH)
    ) u_div_step (
        .p_in    (p),
        .q_in    (q),
        .divisor (dmag),
        .p_out   (p_step),
        .q_out   (q_step)
    );

    // Sign restoration of the raw magnitudes. A zero divisor leaves the
    // dividend in P (so r == a falls out naturally) but Q needs overriding.
    // INT_MIN / -1 needs no special path: the magnitude quotient 2^(WIDTH-1)
    // with a positive sign already reads back as INT_MIN and P is zero.
    always_comb begin
        q_fix = sign_q ? -q : q;
        r_fix = sign_r ? -p : p;
        if (zero) begin
            q_fix = WIDTH'(Q_DIV0);
        end
    end

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs; abort takes priority over the
    // ITER->FIX and FIX->DONE transitions
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ITER;
                end
            end
            ST_ITER: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (count == LAST_CNT) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one restoring step per ITER cycle, result
    // and flag registration in FIX (skipped when the operation is aborted)
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count       <= '0;
            p           <= '0;
            q           <= '0;
            dmag        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero        <= 1'b0;
            z           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        q      <= a_mag;
                        dmag   <= b_mag;
                        p      <= '0;
                        count  <= '0;
                        sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r <= a[WIDTH-1];
                        zero   <= (b == '0);
                    end
                end
                ST_ITER: begin
                    if (!abort) begin
                        p     <= p_step;
                        q     <= q_step;
                        count <= count + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!abort) begin
                        z           <= {r_fix, q_fix};
                        div_by_zero <= zero;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Directed and random self-checking bench for div_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic        abort;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] z;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    div_sequencer #(
        .WIDTH       (32)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .abort       (abort),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .z           (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used to measure done-to-done spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a request in the current cycle, then follow it until busy drops.
    // lat: cycle index (1 = cycle after the accepting edge) where done is seen.
    task automatic run(input logic [31:0] ia, input logic [31:0] ib,
                       output int lat, output int bcnt, output int dcyc);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 0;
        bcnt = 0;
        dcyc = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1 && lat == 0) begin
                lat  = j + 1;
                dcyc = cyc;
            end
            if (busy !== 1'b1) break;
        end
    endtask

    // Reference signed divide with the two architected special cases
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        int qq;
        int rr;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sx = x;
        sy = y;
        qq = sx / sy;
        rr = sx % sy;
        return {rr, qq};
    endfunction

    initial begin
        int lat;
        int bcnt;
        int dc1;
        int dc2;
        int seen;
        int jdone;
        logic [31:0] x;
        logic [31:0] y;

        clr_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dz", div_by_zero, 0);
        chk("reset_z", z, 0);
        clr_n = 1'b1;
        @(negedge clk);

        // Basic 100 / 7
        run(32'd100, 32'd7, lat, bcnt, dc1);
        chk("basic_lat", lat, 34);
        chk("basic_busy_cycles", bcnt, 34);
        chk("basic_z", z, {32'd2, 32'd14});
        chk("basic_dz", div_by_zero, 0);

        // Sign combinations
        @(negedge clk);
        run(32'hFFFF_FF9C, 32'd7, lat, bcnt, dc1);
        chk("neg_a_z", z, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        chk("neg_a_dz", div_by_zero, 0);
        @(negedge clk);
        run(32'd100, 32'hFFFF_FFF9, lat, bcnt, dc1);
        chk("neg_b_z", z, {32'd2, 32'hFFFF_FFF2});
        chk("neg_b_dz", div_by_zero, 0);
        @(negedge clk);
        run(32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, bcnt, dc1);
        chk("neg_ab_z", z, {32'hFFFF_FFFE, 32'd14});
        chk("neg_ab_dz", div_by_zero, 0);

        // INT_MIN / -1 wraps
        @(negedge clk);
        run(32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, dc1);
        chk("ovf_lat", lat, 34);
        chk("ovf_z", z, {32'd0, 32'h8000_0000});
        chk("ovf_dz", div_by_zero, 0);

        // Divide by zero
        @(negedge clk);
        run(32'd5, 32'd0, lat, bcnt, dc1);
        chk("div0_lat", lat, 34);
        chk("div0_z", z, {32'd5, 32'hFFFF_FFFF});
        chk("div0_dz", div_by_zero, 1);

        // Abort in ITER cycle 10: no done, z and flag untouched
        @(negedge clk);
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy_low", busy, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_z_kept", z, {32'd5, 32'hFFFF_FFFF});
        chk("abort_dz_kept", div_by_zero, 1);

        // start pulsed while busy is ignored
        @(negedge clk);
        a     = 32'd45;
        b     = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        jdone = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                jdone = j;
                break;
            end
        end
        chk("ign_start_done_time", jdone, 28);
        chk("ign_start_z", z, {32'd3, 32'd7});
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("ign_start_no_rerun", seen, 0);

        // Asynchronous reset during ITER cycle 20
        @(negedge clk);
        a     = 32'd1000;
        b     = 32'hFFFF_FFDF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_dz", div_by_zero, 0);
        chk("midrst_z", z, 0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        run(32'd1000, 32'hFFFF_FFDF, lat, bcnt, dc1);
        chk("after_rst_lat", lat, 34);
        chk("after_rst_z", z, {32'd10, 32'hFFFF_FFE2});

        // Back-to-back: second start in the first IDLE cycle
        @(negedge clk);
        run(32'd100, 32'd7, lat, bcnt, dc1);
        run(32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, bcnt, dc2);
        chk("b2b_lat", lat, 34);
        chk("b2b_spacing", dc2 - dc1, 35);
        chk("b2b_z", z, {32'hFFFF_FFFE, 32'd14});

        // Random operands against the reference model
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 4 == 0) y = 32'($urandom_range(0, 16)) - 32'd8;
            if (i % 97 == 0) x = 32'h8000_0000;
            run(x, y, lat, bcnt, dc1);
            chk("rand_z", z, model(x, y));
            chk("rand_dz", div_by_zero, (y == 32'd0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
